// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared MMIO offsets, register bit indices and default base for dmem_responder
package dmem_pkg;

    // Byte offsets inside the 256-byte MMIO page
    localparam logic [7:0] OFF_COUNT    = 8'h00;
    localparam logic [7:0] OFF_COMPARE  = 8'h04;
    localparam logic [7:0] OFF_CTRL     = 8'h08;
    localparam logic [7:0] OFF_STATUS   = 8'h0C;
    localparam logic [7:0] OFF_GPIO_OUT = 8'h10;
    localparam logic [7:0] OFF_GPIO_IN  = 8'h14;

    // CTRL bits
    localparam int CTRL_EN = 0;
    localparam int CTRL_IE = 1;
    localparam int CTRL_AR = 2;

    // STATUS bits
    localparam int STAT_MATCH  = 0;
    localparam int STAT_BUSERR = 1;

    localparam logic [31:0] DEFAULT_MMIO_BASE = 32'hFFFF_FF00;

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - core MEM-stage data port bundle
// master: core side (drives MemWriteM, ALUResultM, WriteDataM; receives ReadDataM)
// slave : responder side (returns ReadDataM combinationally)
interface dmem_responder_if;
    logic        MemWriteM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;

    modport master (output MemWriteM, output ALUResultM, output WriteDataM, input ReadDataM);
    modport slave  (input MemWriteM, input ALUResultM, input WriteDataM, output ReadDataM);
endinterface

// File: rtl/mmio_timer.sv
// rtl/mmio_timer.sv - free-running compare timer (COUNT, COMPARE, CTRL, STATUS.match)
// Ports: clk, reset (async active-low), wrEn/wrOff/wrData register-write port,
//        clrMatch W1C clear, count/compare/ctrl/match register state.
// Instantiated by dmem_responder only when DMEM_TIMER_EN is defined.
module mmio_timer
    import dmem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wrEn,
    input  logic [7:0]  wrOff,
    input  logic [31:0] wrData,
    input  logic        clrMatch,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic [2:0]  ctrl,
    output logic        match
);

    // Compare uses the register values of this cycle, so a same-cycle
    // COMPARE write only affects later cycles.
    logic hit;
    assign hit = ctrl[CTRL_EN] && (count == compare);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count   <= '0;
            compare <= '0;
            ctrl    <= '0;
            match   <= 1'b0;
        end else begin
            // Software write to COUNT overrides increment and autoreload
            if (wrEn && wrOff == OFF_COUNT)
                count <= wrData;
            else if (ctrl[CTRL_EN])
                count <= (hit && ctrl[CTRL_AR]) ? 32'd0 : count + 32'd1;

            if (wrEn && wrOff == OFF_COMPARE)
                compare <= wrData;

            if (wrEn && wrOff == OFF_CTRL)
                ctrl <= wrData[2:0];

            // Set beats a simultaneous W1C
            if (hit)
                match <= 1'b1;
            else if (clrMatch)
                match <= 1'b0;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data RAM plus MMIO page (timer, GPIO, sticky bus error) on the core data port
// Ports: clk, reset (async active-low), bus (dmem_responder_if.slave),
//        gpio_in (async inputs), gpio_out, irq (timer level irq), bus_err (sticky).
// Build option: DMEM_TIMER_EN enables the compare timer; otherwise offsets 0x00-0x08
// read 0 and irq is tied low.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] RAM_BASE  = 32'h0000_0000,
    parameter logic [31:0] MMIO_BASE = DEFAULT_MMIO_BASE,
    parameter int          GPIO_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    dmem_responder_if.slave   bus,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              irq,
    output logic              bus_err
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH);

    // Address decode; subtracting the base first makes the range test a single
    // unsigned compare that also rejects addresses below RAM_BASE.
    logic [31:0]   ramOff;
    logic          ramHit;
    logic          mmioHit;
    logic [AW-1:0] ramIdx;
    logic [7:0]    mmioOff;

    assign ramOff  = bus.ALUResultM - RAM_BASE;
    assign ramHit  = ramOff < RAM_BYTES;
    assign ramIdx  = ramOff[AW+1:2];
    assign mmioHit = bus.ALUResultM[31:8] == MMIO_BASE[31:8];
    assign mmioOff = {bus.ALUResultM[7:2], 2'b00};

    logic mmioWr;
    assign mmioWr = bus.MemWriteM && mmioHit;

    // Data RAM: no reset, write at the edge, read combinational
    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (bus.MemWriteM && ramHit)
            mem[ramIdx] <= bus.WriteDataM;
    end

    // Timer block or constant stand-ins
    logic [31:0] count;
    logic [31:0] compare;
    logic [2:0]  ctrl;
    logic        match;

`ifdef DMEM_TIMER_EN
    mmio_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .wrEn     (mmioWr),
        .wrOff    (mmioOff),
        .wrData   (bus.WriteDataM),
        .clrMatch (mmioWr && mmioOff == OFF_STATUS && bus.WriteDataM[STAT_MATCH]),
        .count    (count),
        .compare  (compare),
        .ctrl     (ctrl),
        .match    (match)
    );
`else
    assign count   = '0;
    assign compare = '0;
    assign ctrl    = '0;
    assign match   = 1'b0;
`endif

    // Bus error, GPIO output and gpio_in synchronizer
    logic              busErr;
    logic [GPIO_W-1:0] gpioOut;
    logic [GPIO_W-1:0] gpioSync1;
    logic [GPIO_W-1:0] gpioSync2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busErr    <= 1'b0;
            gpioOut   <= '0;
            gpioSync1 <= '0;
            gpioSync2 <= '0;
        end else begin
            // The core always presents an address, so every unmapped cycle counts
            if (!ramHit && !mmioHit)
                busErr <= 1'b1;
            else if (mmioWr && mmioOff == OFF_STATUS && bus.WriteDataM[STAT_BUSERR])
                busErr <= 1'b0;

            if (mmioWr && mmioOff == OFF_GPIO_OUT)
                gpioOut <= bus.WriteDataM[GPIO_W-1:0];

            gpioSync1 <= gpio_in;
            gpioSync2 <= gpioSync1;
        end
    end

    // Read path
    logic [31:0] mmioRd;

    always_comb begin
        mmioRd = '0;
        case (mmioOff)
            OFF_COUNT:    mmioRd = count;
            OFF_COMPARE:  mmioRd = compare;
            OFF_CTRL:     mmioRd = 32'(ctrl);
            OFF_STATUS:   mmioRd = 32'({busErr, match});
            OFF_GPIO_OUT: mmioRd = 32'(gpioOut);
            OFF_GPIO_IN:  mmioRd = 32'(gpioSync2);
            default:      mmioRd = '0;
        endcase
    end

    assign bus.ReadDataM = ramHit  ? mem[ramIdx] :
                           mmioHit ? mmioRd      : 32'd0;

    assign irq      = match & ctrl[CTRL_IE];
    assign bus_err  = busErr;
    assign gpio_out = gpioOut;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-side responder for the pipelined RISC-V core: receives the core's MEM-stage data port (write strobe, address, write data) and returns read data in the same cycle. Backs a word-addressed data RAM plus a small MMIO register page with a free-running compare timer, GPIO and a sticky bus-error flag. Sits beside the instruction memory at SoC top, wired directly to the core's data port.

## Interface
- DEPTH, 64: data RAM size in 32-bit words; power of two.
- RAM_BASE, 32'h0000_0000: byte base address of the RAM.
- MMIO_BASE, 32'hFFFF_FF00: byte base address of the 256-byte register page.
- GPIO_W, 8: GPIO width.

- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- MemWriteM  in  1  write strobe from the core MEM stage.
- ALUResultM  in  32  byte address.
- WriteDataM  in  32  write data.
- ReadDataM  out  32  read data, combinational from the address.
- gpio_in  in  GPIO_W  asynchronous external inputs.
- gpio_out  out  GPIO_W  GPIO output register.
- irq  out  1  timer interrupt, level.
- bus_err  out  1  sticky out-of-map access flag.

## Operation
- Word access only. ALUResultM[1:0] is ignored. RAM index is (ALUResultM-RAM_BASE)>>2.
- Decode: RAM hit if the address is in [RAM_BASE, RAM_BASE+4*DEPTH); MMIO hit if ALUResultM[31:8]==MMIO_BASE[31:8]; otherwise unmapped.
- MMIO offsets:
  - 0x00 COUNT: RW.
  - 0x04 COMPARE: RW.
  - 0x08 CTRL: bit0 en, bit1 ie, bit2 autoreload; other bits read 0.
  - 0x0C STATUS: bit0 match, bit1 bus_err; write-1-to-clear.
  - 0x10 GPIO_OUT: RW, low GPIO_W bits.
  - 0x14 GPIO_IN: RO; writes are ignored.
  - Other offsets read 0, ignore writes, and do not set bus_err.
- Unmapped read returns 0. An unmapped access (read or write) sets STATUS.bus_err. A read counts only while an address is presented; the core is always presenting one, so bus_err sets on every cycle with an unmapped address.
- Timer, when CTRL.en=1:
  - COUNT increments by 1 per cycle and wraps from 0xFFFF_FFFF to 0.
  - When COUNT==COMPARE, STATUS.match is set at the next edge.
  - With autoreload=1, COUNT loads 0 instead of incrementing on that edge.
- irq = STATUS.match & CTRL.ie.
- bus_err output = STATUS.bus_err.
- gpio_in passes through a 2-flop synchronizer before it is visible in GPIO_IN.

## Timing
- Read path is purely combinational, address to ReadDataM, with zero latency.
- A write commits at the rising clk edge where MemWriteM=1.
- A read of the same address in the write cycle returns the old value; the new value is visible from the next cycle.
- Simultaneous events:
  - A COUNT write in the same cycle as an increment or autoreload: the write wins.
  - A STATUS W1C in the same cycle as a set condition: the set wins.
  - A COMPARE write and a match in the same cycle: the match uses the old COMPARE.
- GPIO_IN latency is 2 cycles from a gpio_in change.
- Reset values:
  - All MMIO registers, synchronizer flops, irq, bus_err and gpio_out are 0.
  - RAM contents are not reset.
  - ReadDataM follows the current address and the reset register state.
- Reset asserted mid-operation clears registers immediately (asynchronous). Release is synchronized by the SoC reset logic.

## Configuration
- DMEM_TIMER_EN defined: COUNT, COMPARE, CTRL, STATUS.match and irq exist as described.
- DMEM_TIMER_EN undefined:
  - Offsets 0x00–0x08 read 0 and ignore writes.
  - STATUS.match is constant 0, so irq is tied 0.
  - bus_err and GPIO are unaffected.

## Structure
- Shared package dmem_pkg holds:
  - MMIO offset localparams: OFF_COUNT, OFF_COMPARE, OFF_CTRL, OFF_STATUS, OFF_GPIO_OUT, OFF_GPIO_IN.
  - CTRL and STATUS bit indices.
  - The default MMIO_BASE.
- One sub-module, mmio_timer: holds COUNT, COMPARE, CTRL and the match logic, with a register-write port and a W1C clear input.
  - Instantiated only under DMEM_TIMER_EN.

## Test plan
- RAM path: write 0xDEADBEEF to 0x0000_0010, read the same address that cycle and the next → 0x0000_0000 (after preload) then 0xDEADBEEF. A read of 0x0000_0013 also returns 0xDEADBEEF.
- Timer:
  - Setup: COMPARE=5, CTRL=0b011, COUNT=0.
  - Without autoreload: STATUS.match and irq go high 6 cycles after enable, and COUNT keeps incrementing.
  - Write STATUS=1 → irq low the next cycle.
  - With CTRL=0b111: COUNT sequence is 0..5,0,1.
- Collisions:
  - Write COUNT=100 on the cycle COUNT==COMPARE under autoreload → COUNT=100.
  - W1C on the cycle a match sets → match stays 1.
- Unmapped access: read 0x8000_0000 → ReadDataM=0 and bus_err=1 the next cycle. A write there leaves RAM unchanged. Write STATUS=2 with a mapped address → bus_err=0.
- GPIO:
  - Write GPIO_OUT=0x1A5 → gpio_out=0xA5 (GPIO_W=8).
  - gpio_in=0x3C → GPIO_IN reads 0x3C after 2 edges; before that, the old value.
- Reset: assert reset between edges with the timer running → COUNT, CTRL, STATUS, gpio_out and irq are 0 immediately. Rebuilding without DMEM_TIMER_EN → reads of offsets 0x00–0x08 return 0 and irq stays 0.
